memory_bus_arbiter: RTL and testbench

Round-robin arbiter that shares one 32-bit single-beat memory port between `NUM_MASTERS` requesters, such as the L1 instruction and data caches of one core or the L1 caches of several cores. Each master drives the same request/address/ready beat protocol the L1 caches use toward memory. The arbiter grants one master at a time and forwards its beats unchanged. It holds the grant across back-to-back beats so a 4-word line refill completes without interleaving, and caps tenure at `MAX_BEATS` while others wait.

---
 rtl/memory_bus_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_memory_bus_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter
//   Round-robin arbiter sharing one 32-bit single-beat memory port between
//   NUM_MASTERS requesters. The owner keeps the port across back-to-back beats
//   and is preempted after MAX_BEATS completed beats if another master waits.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no owner, all memory_* outputs and master_ready are 0
//   GRANTED | grant_index owns the port, its beats are forwarded
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   master_request        per-master beat request (held until master_ready)
//   master_address        per-master word address, master 0 in bits [31:0]
//   master_write_enable   per-master write (1) / read (0)
//   master_write_data     per-master write data, master 0 in bits [31:0]
//   master_ready          beat-complete strobe, owner bit only
//   master_read_data      memory_read_data broadcast
//   grant_valid           a master owns the port
//   grant_index           current owner
//   memory_*              forwarded beat toward the memory slave

module memory_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int MAX_BEATS   = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_MASTERS-1:0]           master_request,
    input  logic [32*NUM_MASTERS-1:0]        master_address,
    input  logic [NUM_MASTERS-1:0]           master_write_enable,
    input  logic [32*NUM_MASTERS-1:0]        master_write_data,
    output logic [NUM_MASTERS-1:0]           master_ready,
    output logic [31:0]                      master_read_data,
    output logic                             grant_valid,
    output logic [$clog2(NUM_MASTERS)-1:0]   grant_index,
    output logic                             memory_request,
    output logic [31:0]                      memory_address,
    output logic                             memory_write_enable,
    output logic [31:0]                      memory_write_data,
    input  logic [31:0]                      memory_read_data,
    input  logic                             memory_ready
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int BC_W  = $clog2(MAX_BEATS + 1);

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    state_t                  state;
    logic [IDX_W-1:0]        rr_ptr;
    logic [BC_W-1:0]         beat_count;
    logic                    preempt_gap;

    logic                    granted;
    logic                    owner_req;
    logic [31:0]             owner_addr;
    logic                    owner_we;
    logic [31:0]             owner_wdata;
    logic [NUM_MASTERS-1:0]  cand;
    logic                    sel_found;
    logic [IDX_W-1:0]        sel_index;
    logic [IDX_W-1:0]        next_ptr;
    int unsigned             scan_idx;
    logic                    beat_done;
    logic                    at_limit;

    assign granted = (state == GRANTED);

    always_comb begin
        owner_req   = 1'b0;
        owner_addr  = '0;
        owner_we    = 1'b0;
        owner_wdata = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_index == IDX_W'(i)) begin
                owner_req   = master_request[i];
                owner_addr  = master_address[i*32 +: 32];
                owner_we    = master_write_enable[i];
                owner_wdata = master_write_data[i*32 +: 32];
            end
        end
    end

    // While granted the owner is masked out of selection: on a drop its
    // request is already low, and on preemption it must not win again.
    always_comb begin
        cand = master_request;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (granted && grant_index == IDX_W'(i)) begin
                cand[i] = 1'b0;
            end
        end
    end

    always_comb begin
        sel_found = 1'b0;
        sel_index = '0;
        scan_idx  = 0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            scan_idx = (32'(rr_ptr) + i) % NUM_MASTERS;
            if (!sel_found && cand[IDX_W'(scan_idx)]) begin
                sel_found = 1'b1;
                sel_index = IDX_W'(scan_idx);
            end
        end
    end

    assign next_ptr  = (sel_index == IDX_W'(NUM_MASTERS - 1)) ? '0 : sel_index + IDX_W'(1);
    assign beat_done = granted && memory_ready;
    assign at_limit  = (beat_count >= BC_W'(MAX_BEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_index <= '0;
            rr_ptr      <= '0;
            beat_count  <= '0;
            preempt_gap <= 1'b0;
        end else begin
            preempt_gap <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        state       <= GRANTED;
                        grant_valid <= 1'b1;
                        grant_index <= sel_index;
                        rr_ptr      <= next_ptr;
                        beat_count  <= '0;
                    end
                end
                GRANTED: begin
                    if (!owner_req) begin
                        // The drop cycle itself is the handoff bubble.
                        if (sel_found) begin
                            grant_index <= sel_index;
                            rr_ptr      <= next_ptr;
                            beat_count  <= '0;
                        end else begin
                            state       <= IDLE;
                            grant_valid <= 1'b0;
                        end
                    end else if (beat_done) begin
                        if (at_limit && sel_found) begin
                            // Preempted right after a completed beat: the new
                            // owner's first cycle carries no request so the
                            // handoff still costs one idle cycle on memory.
                            grant_index <= sel_index;
                            rr_ptr      <= next_ptr;
                            beat_count  <= '0;
                            preempt_gap <= 1'b1;
                        end else if (beat_count != BC_W'(MAX_BEATS)) begin
                            beat_count <= beat_count + BC_W'(1);
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

    assign memory_request      = granted && owner_req && !preempt_gap;
    assign memory_address      = granted ? owner_addr  : '0;
    assign memory_write_enable = granted ? owner_we    : 1'b0;
    assign memory_write_data   = granted ? owner_wdata : '0;
    assign master_read_data    = memory_read_data;

    always_comb begin
        master_ready = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (beat_done && grant_index == IDX_W'(i)) begin
                master_ready[i] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// tb_memory_bus_arbiter
//   Directed bench for memory_bus_arbiter (2 masters, MAX_BEATS = 4).
//   Inputs change 1 ns after the rising edge; outputs are sampled 1-2 ns later.

module tb_memory_bus_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [63:0] addr;
    logic [1:0]  we;
    logic [63:0] wd;
    logic [1:0]  master_ready;
    logic [31:0] master_read_data;
    logic        grant_valid;
    logic [0:0]  grant_index;
    logic        memory_request;
    logic [31:0] memory_address;
    logic        memory_write_enable;
    logic [31:0] memory_write_data;
    logic [31:0] mrd;
    logic        mrdy;

    int n_tests = 0;
    int n_fail  = 0;

    memory_bus_arbiter #(
        .NUM_MASTERS (2),
        .MAX_BEATS   (4)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .master_request      (req),
        .master_address      (addr),
        .master_write_enable (we),
        .master_write_data   (wd),
        .master_ready        (master_ready),
        .master_read_data    (master_read_data),
        .grant_valid         (grant_valid),
        .grant_index         (grant_index),
        .memory_request      (memory_request),
        .memory_address      (memory_address),
        .memory_write_enable (memory_write_enable),
        .memory_write_data   (memory_write_data),
        .memory_read_data    (mrd),
        .memory_ready        (mrdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gv"},    32'(grant_valid), 0);
        check({tag, "_mreq"},  32'(memory_request), 0);
        check({tag, "_maddr"}, memory_address, 0);
        check({tag, "_mwe"},   32'(memory_write_enable), 0);
        check({tag, "_mwd"},   memory_write_data, 0);
        check({tag, "_mrdy"},  32'(master_ready), 0);
    endtask

    initial begin
        clk  = 1'b0;
        rst  = 1'b1;
        req  = '0;
        addr = '0;
        we   = '0;
        wd   = '0;
        mrd  = '0;
        mrdy = 1'b0;

        repeat (2) @(posedge clk);
        #2;
        check_all_zero("reset");
        cyc();
        rst = 1'b0;

        // No requests, memory_ready driven high anyway
        for (int i = 0; i < 20; i++) begin
            cyc();
            mrdy = 1'b1;
            #1;
            check("idle_gv",   32'(grant_valid), 0);
            check("idle_mreq", 32'(memory_request), 0);
            check("idle_mrdy", 32'(master_ready), 0);
        end

        // Master 0 four-beat read, ready every second cycle
        cyc();
        req        = 2'b01;
        addr[31:0] = 32'h100;
        mrdy       = 1'b0;
        #1;
        check("t1_lat_before", 32'(memory_request), 0);
        cyc();
        check("t1_gv",   32'(grant_valid), 1);
        check("t1_gi",   32'(grant_index), 0);
        check("t1_mreq", 32'(memory_request), 1);
        for (int b = 0; b < 4; b++) begin
            if (b != 0) cyc();
            addr[31:0] = 32'h100 + 32'(4 * b);
            mrdy       = 1'b0;
            #1;
            check("t1_addr", memory_address, 32'h100 + 32'(4 * b));
            check("t1_mreq_hold", 32'(memory_request), 1);
            cyc();
            mrdy = 1'b1;
            mrd  = 32'hA000 + 32'(b);
            #1;
            check("t1_ready", 32'(master_ready), 32'b01);
            check("t1_rdata", master_read_data, 32'hA000 + 32'(b));
        end
        cyc();
        req  = 2'b00;
        mrdy = 1'b0;
        #1;
        check("t1_drop_mreq", 32'(memory_request), 0);
        check("t1_drop_gv",   32'(grant_valid), 1);
        cyc();
        check("t1_idle_gv",   32'(grant_valid), 0);

        // Round-robin: pointer now favours master 1
        req         = 2'b11;
        addr[31:0]  = 32'h200;
        addr[63:32] = 32'h300;
        #1;
        check("rr_idle_gv", 32'(grant_valid), 0);
        cyc();
        check("rr_winner", 32'(grant_index), 1);
        check("rr_addr",   memory_address, 32'h300);
        mrdy = 1'b1;
        #1;
        check("rr_ready", 32'(master_ready), 32'b10);
        cyc();
        req  = 2'b01;
        mrdy = 1'b0;
        #1;
        check("rr_drop_gap", 32'(memory_request), 0);
        cyc();
        check("rr_handoff_idx",  32'(grant_index), 0);
        check("rr_handoff_mreq", 32'(memory_request), 1);
        check("rr_handoff_addr", memory_address, 32'h200);
        req = 2'b00;
        cyc();
        check("rr_idle_gv2", 32'(grant_valid), 0);

        // After reset, simultaneous requests: master 0 first
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        req = 2'b11;
        #1;
        check("t2_idle_gv", 32'(grant_valid), 0);
        cyc();
        check("t2_winner", 32'(grant_index), 0);
        mrdy = 1'b1;
        #1;
        check("t2_ready0", 32'(master_ready), 32'b01);
        cyc();
        req  = 2'b10;
        mrdy = 1'b0;
        #1;
        check("t2_drop_gap", 32'(memory_request), 0);
        cyc();
        check("t2_handoff_idx",  32'(grant_index), 1);
        check("t2_handoff_mreq", 32'(memory_request), 1);
        check("t2_handoff_addr", memory_address, 32'h300);
        req = 2'b00;
        cyc();
        check("t2_idle_gv2", 32'(grant_valid), 0);
        req = 2'b11;
        cyc();
        check("t2_rr_favours_0", 32'(grant_index), 0);

        // Master 0 back-to-back beats with master 1 waiting: preempt after 4
        for (int b = 0; b < 4; b++) begin
            if (b != 0) cyc();
            addr[31:0] = 32'h400 + 32'(4 * b);
            mrdy       = 1'b1;
            #1;
            check("pre_addr",  memory_address, 32'h400 + 32'(4 * b));
            check("pre_ready", 32'(master_ready), 32'b01);
            check("pre_owner0", 32'(grant_index), 0);
        end
        cyc();
        addr[31:0]  = 32'h410;
        addr[63:32] = 32'h1000;
        we          = 2'b10;
        wd[63:32]   = 32'hDEADBEEF;
        mrdy        = 1'b0;
        #1;
        check("pre_new_owner", 32'(grant_index), 1);
        check("pre_gap_mreq",  32'(memory_request), 0);
        check("pre_gv",        32'(grant_valid), 1);

        // Write beat from master 1
        cyc();
        check("wr_mreq", 32'(memory_request), 1);
        check("wr_we",   32'(memory_write_enable), 1);
        check("wr_addr", memory_address, 32'h1000);
        check("wr_data", memory_write_data, 32'hDEADBEEF);
        mrdy = 1'b1;
        #1;
        check("wr_ready", 32'(master_ready), 32'b10);
        cyc();
        req  = 2'b01;
        we   = 2'b00;
        mrdy = 1'b0;
        #1;
        check("wr_drop_gap", 32'(memory_request), 0);

        // Master 0 resumes at beat 5
        cyc();
        check("resume_owner", 32'(grant_index), 0);
        check("resume_addr",  memory_address, 32'h410);
        check("resume_mreq",  32'(memory_request), 1);
        check("resume_we",    32'(memory_write_enable), 0);
        mrdy = 1'b1;
        #1;
        check("resume_ready5", 32'(master_ready), 32'b01);
        cyc();
        addr[31:0] = 32'h414;
        #1;
        check("resume_addr6",  memory_address, 32'h414);
        check("resume_ready6", 32'(master_ready), 32'b01);

        // Reset in the middle of a beat
        cyc();
        addr[31:0] = 32'h418;
        mrdy       = 1'b0;
        req        = 2'b11;
        #1;
        check("mid_beat_mreq", 32'(memory_request), 1);
        rst  = 1'b1;
        mrdy = 1'b1;
        #1;
        check_all_zero("async_rst");
        req  = 2'b10;
        mrdy = 1'b0;
        cyc();
        rst = 1'b0;
        #1;
        check("post_rst_gv", 32'(grant_valid), 0);
        cyc();
        check("post_rst_gv1",  32'(grant_valid), 1);
        check("post_rst_gi",   32'(grant_index), 1);
        check("post_rst_mreq", 32'(memory_request), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
